// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// Imported by fetch_ctrl; holds the FSM state encoding and widths.
package fetch_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF   = '0;
    localparam int unsigned       IMEM_WORDS_DEF = 128;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: FSM plus imem address mux.
// Define FETCH_BOUND_CHECK_EN to trap fetches beyond IMEM_WORDS.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int unsigned       IMEM_WORDS = IMEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              dec_ready,
    output logic              fault,
    output logic [1:0]        state
);

    localparam logic [ADDR_W-1:0] LP_LIMIT = ADDR_W'(IMEM_WORDS);

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit LP_CHECK = 1'b1;
`else
    localparam bit LP_CHECK = 1'b0;
`endif

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_req_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic              r_resp_valid;

    fetch_state_e      w_next;
    logic [ADDR_W-1:0] w_addr;
    logic              w_inst_valid;
    logic              w_stall;
    logic              w_oob;

    assign w_inst_valid = r_resp_valid
                        && (r_state == ST_FETCH)
                        && !redirect_valid;

    assign w_stall = w_inst_valid && !dec_ready;

    // Address mux: a stalled word is re-read so rdata stays stable.
    always_comb begin
        w_addr = r_req_pc;
        unique case (r_state)
            ST_BOOT: begin
                w_addr = RESET_PC;
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    w_addr = redirect_target;
                end else if (w_stall) begin
                    w_addr = r_resp_pc;
                end else begin
                    w_addr = r_req_pc;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    w_addr = redirect_target;
                end else begin
                    w_addr = r_resp_pc;
                end
            end
            ST_FAULT: begin
                w_addr = r_resp_pc;
            end
        endcase
    end

    // Constant-folds away entirely when the bound check is disabled.
    assign w_oob = LP_CHECK
                && (r_state == ST_FETCH)
                && (w_addr >= LP_LIMIT);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_BOOT: begin
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_oob) begin
                    w_next = ST_FAULT;
                end else if (redirect_valid) begin
                    w_next = ST_FETCH;
                end else if (halt_req) begin
                    w_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FAULT: begin
                w_next = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_BOOT;
            r_req_pc     <= RESET_PC;
            r_resp_pc    <= RESET_PC;
            r_resp_valid <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_resp_pc    <= w_addr;
            r_req_pc     <= w_addr + ADDR_W'(1);
            r_resp_valid <= (w_next == ST_FETCH);
        end
    end

    assign imem_addr  = w_addr;
    assign inst_out   = imem_rdata;
    assign inst_pc    = r_resp_pc;
    assign inst_valid = w_inst_valid;
    assign state      = r_state;

`ifdef FETCH_BOUND_CHECK_EN
    assign fault = (r_state == ST_FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed table plus
// randomized traffic against a transaction-level model.
module tb_fetch_ctrl;

    localparam logic [31:0] RPC   = 32'd0;
    localparam int unsigned WORDS = 128;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        halt_req = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        dec_ready = 1'b1;
    logic        fault;
    logic [1:0]  state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC  (RPC),
        .IMEM_WORDS(WORDS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .dec_ready      (dec_ready),
        .fault          (fault),
        .state          (state)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Registered instruction memory: data one cycle after address.
    always @(posedge clk) imem_rdata <= memf(imem_addr);

    task automatic cmp(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    typedef struct {
        bit          chk;
        bit          rst;
        bit          rv;
        logic [31:0] rt;
        bit          hlt;
        bit          dr;
        logic [1:0]  st;
        bit          v;
        logic [31:0] pc;
        logic [31:0] addr;
        bit          flt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit c, input bit r, input bit rv,
                       input logic [31:0] rt, input bit h,
                       input bit d, input logic [1:0] s,
                       input bit v, input logic [31:0] p,
                       input logic [31:0] a, input bit f);
        vec_t e;
        e.chk = c; e.rst = r; e.rv = rv; e.rt = rt;
        e.hlt = h; e.dr = d; e.st = s; e.v = v;
        e.pc = p; e.addr = a; e.flt = f;
        tbl.push_back(e);
    endtask

    task automatic drive(input bit r, input bit rv,
                         input logic [31:0] rt,
                         input bit h, input bit d);
        @(negedge clk);
        reset = r;
        redirect_valid = rv;
        redirect_target = rt;
        halt_req = h;
        dec_ready = d;
        #1;
    endtask

    task automatic check_now(input logic [1:0] s, input bit v,
                             input logic [31:0] p,
                             input logic [31:0] a, input bit f);
        cmp("state", 32'(state), 32'(s));
        cmp("inst_valid", 32'(inst_valid), 32'(v));
        cmp("imem_addr", imem_addr, a);
        cmp("fault", 32'(fault), 32'(f));
        if (v) begin
            cmp("inst_pc", inst_pc, p);
            cmp("inst_out", inst_out, memf(p));
        end
    endtask

    // Transaction-level reference: mode, word on offer, held address.
    logic [1:0]  m_mode;
    logic [31:0] m_cur;
    logic [31:0] m_hold;

    task automatic rand_cycle();
        bit r, rv, h, d, ev, ef;
        logic [31:0] rt, ea;
        r  = ($urandom_range(99) == 0);
        rv = ($urandom_range(9) == 0);
        rt = 32'($urandom_range(WORDS + 7));
        h  = ($urandom_range(19) == 0);
        d  = ($urandom_range(9) < 7);
        drive(r, rv, rt, h, d);
        ev = 1'b0;
        ef = 1'b0;
        ea = m_hold;
        case (m_mode)
            S_BOOT:  ea = RPC;
            S_FETCH: begin
                ev = !rv;
                ea = rv ? rt : (d ? m_cur + 32'd1 : m_cur);
            end
            S_HALT:  ea = rv ? rt : m_hold;
            default: ef = 1'b1;
        endcase
        check_now(m_mode, ev, m_cur, ea, ef);
        if (r) begin
            m_mode = S_BOOT;
        end else begin
            case (m_mode)
                S_BOOT: begin
                    m_mode = S_FETCH;
                    m_cur = RPC;
                end
                S_FETCH: begin
                    if (BOUND && ea >= WORDS) begin
                        m_mode = S_FAULT;
                        m_hold = ea;
                    end else if (rv) begin
                        m_cur = rt;
                    end else if (h) begin
                        m_mode = S_HALT;
                        m_hold = ea;
                    end else begin
                        m_cur = ea;
                    end
                end
                S_HALT: begin
                    if (rv) begin
                        m_mode = S_FETCH;
                        m_cur = rt;
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        // Reset, then four consecutive fetches.
        add(0,1,0,0,0,1, S_BOOT ,0,0,0,0);
        add(1,1,0,0,0,1, S_BOOT ,0,0,0,0);
        add(1,0,0,0,0,1, S_BOOT ,0,0,0,0);
        add(1,0,0,0,0,1, S_FETCH,1,0,1,0);
        add(1,0,0,0,0,1, S_FETCH,1,1,2,0);
        add(1,0,0,0,0,1, S_FETCH,1,2,3,0);
        add(1,0,0,0,0,1, S_FETCH,1,3,4,0);
        // Three-cycle stall at pc 2.
        add(1,1,0,0,0,1, S_FETCH,1,4,5,0);
        add(1,1,0,0,0,1, S_BOOT ,0,0,0,0);
        add(1,0,0,0,0,1, S_BOOT ,0,0,0,0);
        add(1,0,0,0,0,1, S_FETCH,1,0,1,0);
        add(1,0,0,0,0,1, S_FETCH,1,1,2,0);
        add(1,0,0,0,0,0, S_FETCH,1,2,2,0);
        add(1,0,0,0,0,0, S_FETCH,1,2,2,0);
        add(1,0,0,0,0,0, S_FETCH,1,2,2,0);
        add(1,0,0,0,0,1, S_FETCH,1,2,3,0);
        add(1,0,0,0,0,1, S_FETCH,1,3,4,0);
        // Redirect to 5 while pc 1 is on offer.
        add(1,1,0,0,0,1, S_FETCH,1,4,5,0);
        add(1,1,0,0,0,1, S_BOOT ,0,0,0,0);
        add(1,0,0,0,0,1, S_BOOT ,0,0,0,0);
        add(1,0,0,0,0,1, S_FETCH,1,0,1,0);
        add(1,0,1,5,0,1, S_FETCH,0,1,5,0);
        add(1,0,0,0,0,1, S_FETCH,1,5,6,0);
        add(1,0,0,0,0,1, S_FETCH,1,6,7,0);
        // Halt at pc 3, then redirect (beating halt) to 0.
        add(1,1,0,0,0,1, S_FETCH,1,7,8,0);
        add(1,1,0,0,0,1, S_BOOT ,0,0,0,0);
        add(1,0,0,0,0,1, S_BOOT ,0,0,0,0);
        add(1,0,0,0,0,1, S_FETCH,1,0,1,0);
        add(1,0,0,0,0,1, S_FETCH,1,1,2,0);
        add(1,0,0,0,0,1, S_FETCH,1,2,3,0);
        add(1,0,0,0,1,1, S_FETCH,1,3,4,0);
        add(1,0,0,0,0,1, S_HALT ,0,0,4,0);
        add(1,0,0,0,1,1, S_HALT ,0,0,4,0);
        add(1,0,1,0,1,1, S_HALT ,0,0,0,0);
        add(1,0,0,0,0,1, S_FETCH,1,0,1,0);
        add(1,0,0,0,0,1, S_FETCH,1,1,2,0);
        // Reset during a stall at pc 4.
        add(1,0,0,0,0,1, S_FETCH,1,2,3,0);
        add(1,0,0,0,0,1, S_FETCH,1,3,4,0);
        add(1,0,0,0,0,0, S_FETCH,1,4,4,0);
        add(1,1,0,0,0,0, S_FETCH,1,4,4,0);
        add(1,1,1,9,0,0, S_BOOT ,0,0,0,0);
        add(1,0,0,0,0,0, S_BOOT ,0,0,0,0);
        add(1,0,0,0,0,0, S_FETCH,1,0,0,0);
        add(1,0,0,0,0,1, S_FETCH,1,0,1,0);
        add(1,0,0,0,0,1, S_FETCH,1,1,2,0);
        // Redirect past the end of instruction memory.
        add(1,0,1,WORDS,0,1, S_FETCH,0,2,WORDS,0);
`ifdef FETCH_BOUND_CHECK_EN
        add(1,0,0,0,0,1, S_FAULT,0,0,WORDS,1);
        add(1,0,1,3,0,1, S_FAULT,0,0,WORDS,1);
        add(1,1,0,0,1,1, S_FAULT,0,0,WORDS,1);
        add(1,0,0,0,0,1, S_BOOT ,0,0,0,0);
`else
        add(1,0,0,0,0,1, S_FETCH,1,WORDS,WORDS+1,0);
        add(1,0,0,0,0,1, S_FETCH,1,WORDS+1,WORDS+2,0);
`endif

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].rv, tbl[i].rt,
                  tbl[i].hlt, tbl[i].dr);
            if (tbl[i].chk)
                check_now(tbl[i].st, tbl[i].v, tbl[i].pc,
                          tbl[i].addr, tbl[i].flt);
        end

        // Re-synchronise the model with a reset, then random traffic.
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 1);
        m_mode = S_BOOT;
        m_cur  = RPC;
        m_hold = RPC;
        for (int k = 0; k < 3000; k++) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 0, the word index fetched first after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 128, the instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-006 SHALL have port redirect_target, input, 32, word index of the redirect destination.
REQ-007 SHALL have port halt_req, input, 1, stop fetching.
REQ-008 SHALL have port imem_addr, output, 32, word index driven to the instruction memory pc input.
REQ-009 SHALL have port imem_rdata, input, 32, instruction memory data; registered in memory, valid one cycle after address.
REQ-010 SHALL have port inst_out, output, 32, instruction to decode (imem_rdata passthrough).
REQ-011 SHALL have port inst_pc, output, 32, word index of inst_out.
REQ-012 SHALL have port inst_valid, output, 1, inst_out/inst_pc valid.
REQ-013 SHALL have port dec_ready, input, 1, decode accepts; transfer when inst_valid and dec_ready are both high.
REQ-014 SHALL have port fault, output, 1, sticky out-of-range fetch indication.
REQ-015 SHALL have port state, output, 2, current FSM state.

Function
REQ-016 SHALL implement FSM states BOOT=0, FETCH=1, HALT=2, FAULT=3.
REQ-017 SHALL hold registers req_pc (address presented this cycle), resp_pc (address whose data is on imem_rdata) and resp_valid.
REQ-018 SHALL drive imem_addr by priority: redirect_valid -> redirect_target; else inst_valid and not dec_ready -> resp_pc (re-read, stall); else req_pc.
REQ-019 SHALL register resp_pc <= imem_addr each cycle and req_pc <= imem_addr + 1 (32-bit, wraps at 2^32).
REQ-020 SHALL set inst_valid = resp_valid and state==FETCH and not redirect_valid; inst_pc = resp_pc.
REQ-021 BOOT SHALL last exactly one cycle presenting RESET_PC, then go to FETCH with resp_valid=1.
REQ-022 In FETCH, first instruction after reset SHALL be valid in the second cycle after reset deasserts; steady-state throughput one instruction per cycle.
REQ-023 Stall: while dec_ready=0, inst_out/inst_pc SHALL remain stable and no instruction is lost or duplicated.
REQ-024 Redirect: cycle n instruction is squashed; cycle n+1 SHALL present inst_pc=redirect_target valid (one bubble).
REQ-025 halt_req in FETCH (no redirect) SHALL go to HALT next cycle; HALT holds imem_addr at resp_pc, inst_valid=0.
REQ-026 HALT SHALL exit to FETCH only on redirect_valid, fetching redirect_target; redirect beats halt_req in the same cycle.
REQ-027 FAULT SHALL be terminal until reset: inst_valid=0, fault=1, imem_addr held.

Reset
REQ-028 reset SHALL set state=BOOT, req_pc=RESET_PC, resp_pc=RESET_PC, resp_valid=0, fault=0, inst_valid=0; reset overrides all inputs, including mid-stall, mid-redirect and in FAULT.

Configuration
REQ-029 With FETCH_BOUND_CHECK_EN defined, an imem_addr >= IMEM_WORDS presented in FETCH SHALL move to FAULT next cycle, suppressing that response.
REQ-030 Without FETCH_BOUND_CHECK_EN, no range check SHALL exist, fault SHALL be tied 0, and FAULT is unreachable.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum, the RESET_PC/IMEM_WORDS defaults and the instruction width constant.
REQ-032 No sub-module SHALL be used; the block is a single FSM plus address mux, instantiated beside the instruction memory.

Verification
REQ-033 Reset then dec_ready=1 -> inst_pc 0,1,2,3 on consecutive cycles with inst_out equal to memory words 0..3.
REQ-034 dec_ready=0 for 3 cycles while inst_pc=2 -> inst_pc/inst_out held at 2; after release, 3 follows with no gap.
REQ-035 redirect_valid with target=5 while inst_pc=1 -> inst_valid=0 that cycle; next cycle inst_pc=5, then 6.
REQ-036 halt_req at inst_pc=3 -> HALT, inst_valid=0; redirect to 0 -> inst_pc=0 next cycle.
REQ-037 FETCH_BOUND_CHECK_EN, redirect target=128 -> state=FAULT, fault=1, inst_valid=0 until reset; reset -> BOOT, fault=0.
REQ-038 reset asserted during a stall at inst_pc=4 -> after release, first valid inst_pc=0.
